// File: rtl/ram_refresh_pkg.sv
// ram_refresh_ctl shared state encoding, timing defaults and counter width.
package ram_refresh_pkg;
  localparam int CNT_W = 3;
  localparam int RAS_CYC_DEF = 4;
  localparam int RP_CYC_DEF = 2;
  localparam int REF_CYC_DEF = 3;

  typedef enum logic [2:0] {
    IDLE,
    ACC_ROW,
    ACC_COL,
    ACC_CAS,
    REF_CAS,
    REF_RAS,
    PRE
  } state_t;

  function automatic logic [CNT_W-1:0] cnt_ld(input int n);
    return n[CNT_W-1:0];
  endfunction
endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer with asynchronous active-low reset.
module sync2 (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);
  logic r_q1;
  logic r_q2;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q1 <= 1'b0;
      r_q2 <= 1'b0;
    end else begin
      r_q1 <= i_d;
      r_q2 <= r_q1;
    end
  end

  assign o_q = r_q2;
endmodule

// File: rtl/ram_refresh_ctl.sv
// DRAM access / CAS-before-RAS refresh sequencer in the FCLK domain.
// Define REF_MISS_EN to add the RefMiss overrun counter output.
module ram_refresh_ctl
  import ram_refresh_pkg::*;
#(
  parameter int RAS_CYC = RAS_CYC_DEF,
  parameter int RP_CYC  = RP_CYC_DEF,
  parameter int REF_CYC = REF_CYC_DEF
) (
  input  logic       FCLK,
  input  logic       nRES,
  input  logic       RefReq,
  input  logic       RefUrgent,
  input  logic       BACT,
  input  logic       RAMCS,
  input  logic       nUDS,
  input  logic       nLDS,
  output logic       nRAS,
  output logic       nCASH,
  output logic       nCASL,
  output logic       RASEL,
  output logic       RAMReady,
  output logic       RefDone
`ifdef REF_MISS_EN
  ,
  output logic [3:0] RefMiss
`endif
);
  localparam logic [CNT_W-1:0] L_ONE = cnt_ld(1);
  localparam logic [CNT_W-1:0] L_CAS = cnt_ld(RAS_CYC - 2);
  localparam logic [CNT_W-1:0] L_REF = cnt_ld(REF_CYC);
  localparam logic [CNT_W-1:0] L_RP  = cnt_ld(RP_CYC);

  state_t           r_state;
  state_t           w_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_pend;
  logic             r_req_d;
  logic             r_served;
  logic             r_done;
  logic             w_req_s;
  logic             w_urg_s;
  logic             w_rise;
  logic             w_acc_req;
  logic             w_last;
  logic             w_ras_n;
  logic             w_cash_n;
  logic             w_casl_n;
  logic             w_rasel;
  logic             w_ready;
  logic             w_done;

  sync2 u_sync_req (
    .i_clk  (FCLK),
    .i_rst_n(nRES),
    .i_d    (RefReq),
    .o_q    (w_req_s)
  );

  sync2 u_sync_urg (
    .i_clk  (FCLK),
    .i_rst_n(nRES),
    .i_d    (RefUrgent),
    .o_q    (w_urg_s)
  );

  assign w_rise    = w_req_s & ~r_req_d;
  assign w_acc_req = BACT & RAMCS & ~r_served;
  assign w_last    = (r_cnt == L_ONE);

  always_comb begin
    w_nxt     = r_state;
    w_cnt_nxt = w_last ? L_ONE : r_cnt - L_ONE;
    w_ras_n   = 1'b1;
    w_cash_n  = 1'b1;
    w_casl_n  = 1'b1;
    w_rasel   = 1'b1;
    w_ready   = 1'b0;
    w_done    = 1'b0;
    unique case (r_state)
      IDLE: begin
        // an overdue refresh outranks a waiting CPU access
        if (r_pend & w_urg_s) w_nxt = REF_CAS;
        else if (w_acc_req) w_nxt = ACC_ROW;
        else if (r_pend) w_nxt = REF_CAS;
        w_cnt_nxt = L_ONE;
      end
      ACC_ROW: begin
        w_ras_n   = 1'b0;
        w_nxt     = ACC_COL;
        w_cnt_nxt = L_ONE;
      end
      ACC_COL: begin
        w_ras_n   = 1'b0;
        w_rasel   = 1'b0;
        w_nxt     = ACC_CAS;
        w_cnt_nxt = L_CAS;
      end
      ACC_CAS: begin
        w_ras_n  = 1'b0;
        w_rasel  = 1'b0;
        w_cash_n = nUDS;
        w_casl_n = nLDS;
        if (w_last) begin
          w_ready   = 1'b1;
          w_nxt     = PRE;
          w_cnt_nxt = L_RP;
        end
      end
      REF_CAS: begin
        w_cash_n  = 1'b0;
        w_casl_n  = 1'b0;
        w_nxt     = REF_RAS;
        w_cnt_nxt = L_REF;
      end
      REF_RAS: begin
        w_ras_n  = 1'b0;
        w_cash_n = 1'b0;
        w_casl_n = 1'b0;
        if (w_last) begin
          w_done    = 1'b1;
          w_nxt     = PRE;
          w_cnt_nxt = L_RP;
        end
      end
      PRE: begin
        if (w_last) w_nxt = IDLE;
      end
      default: w_nxt = IDLE;
    endcase
  end

  always_ff @(posedge FCLK or negedge nRES) begin
    if (!nRES) begin
      r_state  <= IDLE;
      r_cnt    <= L_ONE;
      r_pend   <= 1'b0;
      r_req_d  <= 1'b0;
      r_served <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_cnt   <= w_cnt_nxt;
      r_req_d <= w_req_s;
      r_done  <= w_done;
      if (w_rise) r_pend <= 1'b1;
      else if (r_done) r_pend <= 1'b0;
      if (!BACT) r_served <= 1'b0;
      else if (w_ready) r_served <= 1'b1;
    end
  end

`ifdef REF_MISS_EN
  logic [3:0] r_miss;

  always_ff @(posedge FCLK or negedge nRES) begin
    if (!nRES) begin
      r_miss <= 4'd0;
    end else if (w_rise & r_pend & ~r_done & (r_miss != 4'd15)) begin
      r_miss <= r_miss + 4'd1;
    end
  end

  assign RefMiss = r_miss;
`endif

  assign nRAS     = w_ras_n;
  assign nCASH    = w_cash_n;
  assign nCASL    = w_casl_n;
  assign RASEL    = w_rasel;
  assign RAMReady = w_ready;
  assign RefDone  = r_done;
endmodule
